// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions: opcodes, ALUOp encodings, control bundle and
// the opcode-to-control table used by the ID stage.
package mips_defs_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = 8'h00;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = CTRL_NONE;
      case (op)
         OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_FUNCT; end
         OP_LW:    begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
         OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
         OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
         OP_BEQ:   c.alu_op = ALUOP_SUB;
         OP_BNE:   c.alu_op = ALUOP_SUB;
         default:  c = CTRL_NONE;
      endcase
      return c;
   endfunction

   function automatic logic is_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/stage2_decode_if.sv
// Bundle of fetch-side, hazard, write-back and ID/EX signals around the decode stage.
interface stage2_decode_if;
   logic [31:0] Instr_in;
   logic [31:0] PC_in;
   logic [31:0] PCPlus4_in;
   logic        ExcFlush;
   logic        IDEX_MemRead;
   logic        IDEX_RegWrite;
   logic [4:0]  IDEX_WriteReg;
   logic        EXMEM_RegWrite;
   logic [4:0]  EXMEM_WriteReg;
   logic        WB_RegWrite;
   logic [4:0]  WB_WriteReg;
   logic [31:0] WB_WriteData;

   logic        PCWrite;
   logic [1:0]  PCSrc;
   logic [31:0] PCPlus4PlusOff;
   logic [31:0] JmpAddr;
   logic [31:0] PC_stage2;
   logic [31:0] PCPlus4_out;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] SignExtImm;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [5:0]  Funct;
   logic        RegDst;
   logic        ALUSrc;
   logic        MemtoReg;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  ALUOp;
   logic        Bubble;
   logic        IllegalInstr;

   modport slave (
      input  Instr_in, PC_in, PCPlus4_in, ExcFlush,
      input  IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
      input  EXMEM_RegWrite, EXMEM_WriteReg,
      input  WB_RegWrite, WB_WriteReg, WB_WriteData,
      output PCWrite, PCSrc, PCPlus4PlusOff, JmpAddr, PC_stage2, PCPlus4_out,
      output ReadData1, ReadData2, SignExtImm, Rs, Rt, Rd, Funct,
      output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp,
      output Bubble, IllegalInstr
   );

   modport master (
      output Instr_in, PC_in, PCPlus4_in, ExcFlush,
      output IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg,
      output EXMEM_RegWrite, EXMEM_WriteReg,
      output WB_RegWrite, WB_WriteReg, WB_WriteData,
      input  PCWrite, PCSrc, PCPlus4PlusOff, JmpAddr, PC_stage2, PCPlus4_out,
      input  ReadData1, ReadData2, SignExtImm, Rs, Rt, Rd, Funct,
      input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp,
      input  Bubble, IllegalInstr
   );
endinterface

// File: rtl/stage2_decode_reg_file.sv
// 32x32 register file: two async read ports with write-through, one sync write
// port, $0 hardwired to zero.
module reg_file_32x32 #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  i_raddr1,
   input  logic [4:0]  i_raddr2,
   output logic [31:0] o_rdata1,
   output logic [31:0] o_rdata2,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata
);
   logic [31:0] r_mem [0:31];
   logic        w_wr_en;

   assign w_wr_en = i_we && (i_waddr != 5'd0);

   // storage update; writes to $0 are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            r_mem[i] <= RESET_VAL;
         end
      end else if (w_wr_en) begin
         r_mem[i_waddr] <= i_wdata;
      end else begin
         r_mem[i_waddr] <= r_mem[i_waddr];
      end
   end

   // read port 1 with same-cycle write-through
   always_comb begin
      o_rdata1 = 32'h0000_0000;
      if (i_raddr1 == 5'd0) begin
         o_rdata1 = 32'h0000_0000;
      end else if (w_wr_en && (i_waddr == i_raddr1)) begin
         o_rdata1 = i_wdata;
      end else begin
         o_rdata1 = r_mem[i_raddr1];
      end
   end

   // read port 2 with same-cycle write-through
   always_comb begin
      o_rdata2 = 32'h0000_0000;
      if (i_raddr2 == 5'd0) begin
         o_rdata2 = 32'h0000_0000;
      end else if (w_wr_en && (i_waddr == i_raddr2)) begin
         o_rdata2 = i_wdata;
      end else begin
         o_rdata2 = r_mem[i_raddr2];
      end
   end
endmodule

// File: rtl/stage2_decode.sv
// MIPS instruction-decode stage: IF/ID register, register file, control decode,
// branch/jump resolution and load-use / branch hazard stalls.
module stage2_decode #(
   parameter logic [31:0] NOP_INSTR     = 32'h0000_0000,
   parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   stage2_decode_if.slave  bus
);
   import mips_defs_pkg::*;

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [31:0] r_pcplus4;

   logic [5:0]  w_op;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [31:0] w_sext;
   logic [31:0] w_rdata1;
   logic [31:0] w_rdata2;
   ctrl_t       w_ctrl;
   logic        w_illegal;
   logic        w_is_beq;
   logic        w_is_bne;
   logic        w_is_j;
   logic        w_uses_rt;
   logic        w_load_use;
   logic        w_br_hazard;
   logic        w_stall;
   logic        w_bubble;
   logic        w_taken;
   logic [1:0]  w_pcsrc;

   assign w_op   = r_instr[31:26];
   assign w_rs   = r_instr[25:21];
   assign w_rt   = r_instr[20:16];
   assign w_sext = {{16{r_instr[15]}}, r_instr[15:0]};

   reg_file_32x32 #(.RESET_VAL(REG_RESET_VAL)) u_rf (
      .clk      (clk),
      .rst_n    (reset),
      .i_raddr1 (w_rs),
      .i_raddr2 (w_rt),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2),
      .i_we     (bus.WB_RegWrite),
      .i_waddr  (bus.WB_WriteReg),
      .i_wdata  (bus.WB_WriteData)
   );

   // opcode decode; the canonical NOP carries no control so squashed slots look empty
   always_comb begin
      w_ctrl    = CTRL_NONE;
      w_illegal = 1'b0;
      w_is_beq  = 1'b0;
      w_is_bne  = 1'b0;
      w_is_j    = 1'b0;
      w_uses_rt = 1'b0;
      if (r_instr == NOP_INSTR) begin
         w_ctrl = CTRL_NONE;
      end else begin
         w_ctrl    = decode_ctrl(w_op);
         w_illegal = !is_supported(w_op);
         w_is_beq  = (w_op == OP_BEQ);
         w_is_bne  = (w_op == OP_BNE);
         w_is_j    = (w_op == OP_J);
         w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) || w_is_beq || w_is_bne;
      end
   end

   // hazard detection and redirect resolution
   always_comb begin
      w_load_use = bus.IDEX_MemRead && (bus.IDEX_WriteReg != 5'd0) &&
                   ((bus.IDEX_WriteReg == w_rs) || (w_uses_rt && (bus.IDEX_WriteReg == w_rt)));
      w_br_hazard = 1'b0;
      if (w_is_beq || w_is_bne) begin
         w_br_hazard =
            (bus.IDEX_RegWrite && (bus.IDEX_WriteReg != 5'd0) &&
             ((bus.IDEX_WriteReg == w_rs) || (bus.IDEX_WriteReg == w_rt))) ||
            (bus.EXMEM_RegWrite && (bus.EXMEM_WriteReg != 5'd0) &&
             ((bus.EXMEM_WriteReg == w_rs) || (bus.EXMEM_WriteReg == w_rt)));
      end else begin
         w_br_hazard = 1'b0;
      end
      w_stall  = w_load_use || w_br_hazard;
      w_bubble = w_stall || bus.ExcFlush;
      w_taken  = (w_is_beq && (w_rdata1 == w_rdata2)) || (w_is_bne && (w_rdata1 != w_rdata2));
      if (w_bubble) begin
         w_pcsrc = 2'b00;
      end else begin
         w_pcsrc = {w_is_j, w_taken};
      end
   end

   // IF/ID pipeline register: flush > stall > redirect squash > load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr   <= NOP_INSTR;
         r_pc      <= 32'h0000_0000;
         r_pcplus4 <= 32'h0000_0000;
      end else if (bus.ExcFlush) begin
         r_instr   <= NOP_INSTR;
         r_pc      <= 32'h0000_0000;
         r_pcplus4 <= 32'h0000_0000;
      end else if (w_stall) begin
         r_instr   <= r_instr;
         r_pc      <= r_pc;
         r_pcplus4 <= r_pcplus4;
      end else if (w_pcsrc != 2'b00) begin
         r_instr   <= NOP_INSTR;
         r_pc      <= 32'h0000_0000;
         r_pcplus4 <= 32'h0000_0000;
      end else begin
         r_instr   <= bus.Instr_in;
         r_pc      <= bus.PC_in;
         r_pcplus4 <= bus.PCPlus4_in;
      end
   end

   assign bus.PCWrite        = bus.ExcFlush || !w_stall;
   assign bus.PCSrc          = w_pcsrc;
   assign bus.PCPlus4PlusOff = r_pcplus4 + {w_sext[29:0], 2'b00};
   assign bus.JmpAddr        = {r_pcplus4[31:28], r_instr[25:0], 2'b00};
   assign bus.PC_stage2      = r_pc;
   assign bus.PCPlus4_out    = r_pcplus4;
   assign bus.ReadData1      = w_rdata1;
   assign bus.ReadData2      = w_rdata2;
   assign bus.SignExtImm     = w_sext;
   assign bus.Rs             = w_rs;
   assign bus.Rt             = w_rt;
   assign bus.Rd             = r_instr[15:11];
   assign bus.Funct          = r_instr[5:0];
   assign bus.RegDst         = w_bubble ? 1'b0 : w_ctrl.reg_dst;
   assign bus.ALUSrc         = w_bubble ? 1'b0 : w_ctrl.alu_src;
   assign bus.MemtoReg       = w_bubble ? 1'b0 : w_ctrl.mem_to_reg;
   assign bus.RegWrite       = w_bubble ? 1'b0 : w_ctrl.reg_write;
   assign bus.MemRead        = w_bubble ? 1'b0 : w_ctrl.mem_read;
   assign bus.MemWrite       = w_bubble ? 1'b0 : w_ctrl.mem_write;
   assign bus.ALUOp          = w_bubble ? 2'b00 : w_ctrl.alu_op;
   assign bus.Bubble         = w_bubble;
   assign bus.IllegalInstr   = w_illegal;
endmodule

// File: tb/tb_stage2_decode.sv
// Directed-vector bench for stage2_decode with hand-computed expectations.
module tb_stage2_decode;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   stage2_decode_if bus();
   stage2_decode dut (.clk(clk), .reset(reset), .bus(bus));

   logic [7:0] ctl;
   assign ctl = {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
                 bus.MemRead, bus.MemWrite, bus.ALUOp};

   localparam logic [7:0] C_R    = 8'b1001_0010;
   localparam logic [7:0] C_LW   = 8'b0111_1000;
   localparam logic [7:0] C_SW   = 8'b0100_0100;
   localparam logic [7:0] C_ADDI = 8'b0101_0000;
   localparam logic [7:0] C_BR   = 8'b0000_0001;
   localparam logic [7:0] C_NONE = 8'b0000_0000;

   localparam logic [31:0] I_ADD_6_5_0  = 32'h00A0_3020;
   localparam logic [31:0] I_ADD_9_8_10 = 32'h010A_4820;
   localparam logic [31:0] I_LW         = 32'h8C23_FFFC;
   localparam logic [31:0] I_SW         = 32'hAC44_0008;
   localparam logic [31:0] I_ADDI       = 32'h2007_FFFF;
   localparam logic [31:0] I_BEQ        = 32'h1022_0004;
   localparam logic [31:0] I_BNE        = 32'h1422_0004;
   localparam logic [31:0] I_J          = 32'h0810_0000;
   localparam logic [31:0] I_ILL        = 32'hFC00_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      bus.Instr_in = 32'h0; bus.PC_in = 32'h0; bus.PCPlus4_in = 32'h0;
      bus.ExcFlush = 1'b0;
      bus.IDEX_MemRead = 1'b0; bus.IDEX_RegWrite = 1'b0; bus.IDEX_WriteReg = 5'd0;
      bus.EXMEM_RegWrite = 1'b0; bus.EXMEM_WriteReg = 5'd0;
      bus.WB_RegWrite = 1'b0; bus.WB_WriteReg = 5'd0; bus.WB_WriteData = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
      bus.Instr_in = instr; bus.PC_in = pc; bus.PCPlus4_in = pc + 32'd4;
      tick();
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = r; bus.WB_WriteData = d;
      tick();
      bus.WB_RegWrite = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (bus.PCWrite !== 1'b1) begin n_bad++; $display("FAIL rst_pcwrite got %b exp 1", bus.PCWrite); end
      n_cmp++; if (bus.PCSrc !== 2'b00) begin n_bad++; $display("FAIL rst_pcsrc got %b exp 00", bus.PCSrc); end
      n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL rst_ctl got %b exp %b", ctl, C_NONE); end
      n_cmp++; if ({bus.Bubble, bus.IllegalInstr} !== 2'b00) begin n_bad++; $display("FAIL rst_bub_ill got %b exp 00", {bus.Bubble, bus.IllegalInstr}); end
      n_cmp++; if (bus.PC_stage2 !== 32'h0) begin n_bad++; $display("FAIL rst_pc got %h exp 0", bus.PC_stage2); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_decode_types();
      idle();
      fetch(I_LW, 32'h10);
      n_cmp++; if (ctl !== C_LW) begin n_bad++; $display("FAIL lw_ctl got %b exp %b", ctl, C_LW); end
      n_cmp++; if (bus.SignExtImm !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL lw_imm got %h exp fffffffc", bus.SignExtImm); end
      n_cmp++; if ({bus.Rs, bus.Rt} !== {5'd1, 5'd3}) begin n_bad++; $display("FAIL lw_regs got %h exp %h", {bus.Rs, bus.Rt}, {5'd1, 5'd3}); end
      n_cmp++; if ({bus.PC_stage2, bus.PCPlus4_out} !== {32'h10, 32'h14}) begin n_bad++; $display("FAIL lw_pc got %h exp %h", {bus.PC_stage2, bus.PCPlus4_out}, {32'h10, 32'h14}); end
      fetch(I_SW, 32'h14);
      n_cmp++; if (ctl !== C_SW) begin n_bad++; $display("FAIL sw_ctl got %b exp %b", ctl, C_SW); end
      fetch(I_ADDI, 32'h18);
      n_cmp++; if (ctl !== C_ADDI) begin n_bad++; $display("FAIL addi_ctl got %b exp %b", ctl, C_ADDI); end
      n_cmp++; if (bus.SignExtImm !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL addi_imm got %h exp ffffffff", bus.SignExtImm); end
   endtask

   task automatic test_write_through();
      idle();
      fetch(I_ADD_6_5_0, 32'h20);
      n_cmp++; if (ctl !== C_R) begin n_bad++; $display("FAIL r_ctl got %b exp %b", ctl, C_R); end
      n_cmp++; if ({bus.Rd, bus.Funct} !== {5'd6, 6'h20}) begin n_bad++; $display("FAIL r_rd_funct got %h exp %h", {bus.Rd, bus.Funct}, {5'd6, 6'h20}); end
      bus.WB_RegWrite = 1'b1; bus.WB_WriteReg = 5'd5; bus.WB_WriteData = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (bus.ReadData1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wt_rd1 got %h exp deadbeef", bus.ReadData1); end
      tick();
      bus.WB_WriteReg = 5'd0; bus.WB_WriteData = 32'h0000_1234;
      #1;
      n_cmp++; if (bus.ReadData2 !== 32'h0) begin n_bad++; $display("FAIL wt_r0 got %h exp 0", bus.ReadData2); end
      n_cmp++; if (bus.ReadData1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wt_stored got %h exp deadbeef", bus.ReadData1); end
      tick();
      bus.WB_RegWrite = 1'b0;
      #1;
      n_cmp++; if (bus.ReadData2 !== 32'h0) begin n_bad++; $display("FAIL r0_after got %h exp 0", bus.ReadData2); end
   endtask

   task automatic test_load_use();
      idle();
      fetch(I_ADD_9_8_10, 32'h40);
      bus.IDEX_MemRead = 1'b1; bus.IDEX_WriteReg = 5'd8;
      bus.Instr_in = I_ADDI; bus.PC_in = 32'h44; bus.PCPlus4_in = 32'h48;
      #1;
      n_cmp++; if ({bus.PCWrite, bus.Bubble, bus.RegWrite, bus.PCSrc} !== 5'b01000) begin n_bad++; $display("FAIL lu_stall got %b exp 01000", {bus.PCWrite, bus.Bubble, bus.RegWrite, bus.PCSrc}); end
      tick();
      n_cmp++; if ({bus.PC_stage2, bus.Rd} !== {32'h40, 5'd9}) begin n_bad++; $display("FAIL lu_hold got %h exp %h", {bus.PC_stage2, bus.Rd}, {32'h40, 5'd9}); end
      bus.IDEX_WriteReg = 5'd10;
      #1;
      n_cmp++; if (bus.PCWrite !== 1'b0) begin n_bad++; $display("FAIL lu_rt got %b exp 0", bus.PCWrite); end
      bus.IDEX_MemRead = 1'b0;
      #1;
      n_cmp++; if ({bus.PCWrite, bus.Bubble, bus.RegWrite} !== 3'b101) begin n_bad++; $display("FAIL lu_release got %b exp 101", {bus.PCWrite, bus.Bubble, bus.RegWrite}); end
      tick();
      bus.IDEX_MemRead = 1'b1; bus.IDEX_WriteReg = 5'd7;
      #1;
      n_cmp++; if (bus.PCWrite !== 1'b1) begin n_bad++; $display("FAIL lu_addi_rt got %b exp 1", bus.PCWrite); end
      bus.IDEX_WriteReg = 5'd0;
      #1;
      n_cmp++; if (bus.PCWrite !== 1'b1) begin n_bad++; $display("FAIL lu_reg0 got %b exp 1", bus.PCWrite); end
      bus.IDEX_MemRead = 1'b0;
   endtask

   task automatic test_branch();
      idle();
      wb_write(5'd1, 32'd7);
      wb_write(5'd2, 32'd7);
      fetch(I_BEQ, 32'h100);
      n_cmp++; if (bus.PCSrc !== 2'b01) begin n_bad++; $display("FAIL beq_pcsrc got %b exp 01", bus.PCSrc); end
      n_cmp++; if (bus.PCPlus4PlusOff !== 32'h114) begin n_bad++; $display("FAIL beq_target got %h exp 114", bus.PCPlus4PlusOff); end
      n_cmp++; if (ctl !== C_BR) begin n_bad++; $display("FAIL beq_ctl got %b exp %b", ctl, C_BR); end
      bus.Instr_in = I_ADD_6_5_0; bus.PC_in = 32'h104; bus.PCPlus4_in = 32'h108;
      tick();
      n_cmp++; if ({bus.PC_stage2, ctl, bus.PCSrc} !== {32'h0, C_NONE, 2'b00}) begin n_bad++; $display("FAIL beq_squash got %h exp %h", {bus.PC_stage2, ctl, bus.PCSrc}, {32'h0, C_NONE, 2'b00}); end
      fetch(I_BNE, 32'h120);
      n_cmp++; if (bus.PCSrc !== 2'b00) begin n_bad++; $display("FAIL bne_nt got %b exp 00", bus.PCSrc); end
      bus.EXMEM_RegWrite = 1'b1; bus.EXMEM_WriteReg = 5'd2;
      #1;
      n_cmp++; if ({bus.PCWrite, bus.Bubble, bus.PCSrc} !== 4'b0100) begin n_bad++; $display("FAIL br_exmem_stall got %b exp 0100", {bus.PCWrite, bus.Bubble, bus.PCSrc}); end
      bus.EXMEM_RegWrite = 1'b0;
      fetch(I_BEQ, 32'h100);
      bus.IDEX_RegWrite = 1'b1; bus.IDEX_WriteReg = 5'd1;
      bus.Instr_in = I_ADD_6_5_0; bus.PC_in = 32'h104; bus.PCPlus4_in = 32'h108;
      #1;
      n_cmp++; if ({bus.PCWrite, bus.PCSrc} !== 3'b000) begin n_bad++; $display("FAIL br_idex_stall got %b exp 000", {bus.PCWrite, bus.PCSrc}); end
      tick();
      n_cmp++; if (bus.PC_stage2 !== 32'h100) begin n_bad++; $display("FAIL br_hold got %h exp 100", bus.PC_stage2); end
      bus.IDEX_RegWrite = 1'b0;
      #1;
      n_cmp++; if (bus.PCSrc !== 2'b01) begin n_bad++; $display("FAIL br_resolve got %b exp 01", bus.PCSrc); end
      idle();
      tick();
   endtask

   task automatic test_jump();
      idle();
      fetch(I_J, 32'h200);
      n_cmp++; if (bus.PCSrc !== 2'b10) begin n_bad++; $display("FAIL j_pcsrc got %b exp 10", bus.PCSrc); end
      n_cmp++; if (bus.JmpAddr !== 32'h0040_0000) begin n_bad++; $display("FAIL j_addr got %h exp 00400000", bus.JmpAddr); end
      n_cmp++; if ({ctl, bus.IllegalInstr} !== {C_NONE, 1'b0}) begin n_bad++; $display("FAIL j_ctl got %h exp 0", {ctl, bus.IllegalInstr}); end
      bus.Instr_in = I_ADD_6_5_0; bus.PC_in = 32'h204; bus.PCPlus4_in = 32'h208;
      tick();
      n_cmp++; if ({bus.PC_stage2, bus.PCSrc} !== {32'h0, 2'b00}) begin n_bad++; $display("FAIL j_squash got %h exp 0", {bus.PC_stage2, bus.PCSrc}); end
      fetch(I_J, 32'hF000_0100);
      n_cmp++; if (bus.JmpAddr !== 32'hF040_0000) begin n_bad++; $display("FAIL j_region got %h exp f0400000", bus.JmpAddr); end
      idle();
      tick();
   endtask

   task automatic test_illegal();
      idle();
      fetch(I_ILL, 32'h300);
      n_cmp++; if ({bus.IllegalInstr, ctl, bus.PCSrc, bus.PCWrite, bus.Bubble} !== {1'b1, C_NONE, 2'b00, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ill_decode got %h exp %h", {bus.IllegalInstr, ctl, bus.PCSrc, bus.PCWrite, bus.Bubble}, {1'b1, C_NONE, 2'b00, 1'b1, 1'b0}); end
      bus.ExcFlush = 1'b1;
      bus.Instr_in = I_ADD_6_5_0; bus.PC_in = 32'h304; bus.PCPlus4_in = 32'h308;
      #1;
      n_cmp++; if ({bus.Bubble, bus.PCWrite, bus.PCSrc} !== 4'b1100) begin n_bad++; $display("FAIL flush_out got %b exp 1100", {bus.Bubble, bus.PCWrite, bus.PCSrc}); end
      tick();
      bus.ExcFlush = 1'b0;
      #1;
      n_cmp++; if ({bus.IllegalInstr, bus.PC_stage2} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL flush_nop got %h exp 0", {bus.IllegalInstr, bus.PC_stage2}); end
   endtask

   task automatic test_reset_mid_stall();
      idle();
      wb_write(5'd8, 32'h55);
      fetch(I_ADD_9_8_10, 32'h40);
      n_cmp++; if (bus.ReadData1 !== 32'h55) begin n_bad++; $display("FAIL rs_pre got %h exp 55", bus.ReadData1); end
      bus.IDEX_MemRead = 1'b1; bus.IDEX_WriteReg = 5'd8;
      #1;
      n_cmp++; if (bus.PCWrite !== 1'b0) begin n_bad++; $display("FAIL rs_stall got %b exp 0", bus.PCWrite); end
      reset = 1'b0;
      #1;
      n_cmp++; if ({bus.PCWrite, bus.PCSrc, bus.Bubble, bus.PC_stage2} !== {1'b1, 2'b00, 1'b0, 32'h0}) begin n_bad++; $display("FAIL rs_async got %h exp %h", {bus.PCWrite, bus.PCSrc, bus.Bubble, bus.PC_stage2}, {1'b1, 2'b00, 1'b0, 32'h0}); end
      bus.IDEX_MemRead = 1'b0; bus.IDEX_WriteReg = 5'd0;
      bus.Instr_in = I_ADD_9_8_10; bus.PC_in = 32'h400; bus.PCPlus4_in = 32'h404;
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.PC_stage2 !== 32'h0) begin n_bad++; $display("FAIL rs_not_yet got %h exp 0", bus.PC_stage2); end
      tick();
      n_cmp++; if ({bus.PC_stage2, bus.Rd} !== {32'h400, 5'd9}) begin n_bad++; $display("FAIL rs_first got %h exp %h", {bus.PC_stage2, bus.Rd}, {32'h400, 5'd9}); end
      n_cmp++; if (bus.ReadData1 !== 32'h0) begin n_bad++; $display("FAIL rs_regclr got %h exp 0", bus.ReadData1); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      idle();
      test_reset();
      test_decode_types();
      test_write_through();
      test_load_use();
      test_branch();
      test_jump();
      test_illegal();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
